zeroriscy_mp_sram: RTL and testbench
====================================

Name: zeroriscy_mp_sram

Overview:
- Parametrised N-port instruction/data SRAM model for zero-riscy simulation benches.
- Successor to the fixed two-port test memory. Differences:
  - any port may write;
  - read latency is configurable;
  - out-of-range accesses return an error response;
  - same-word write collisions between ports are resolved deterministically.
- Sits between the core's instruction/data OBI-style ports and the bench.

Parameters:
- NPORTS, 2, number of request ports (1..4)
- IWORDS, 4096, imem depth in 32-bit words (power of 2)
- DWORDS, 65536, dmem depth in 32-bit words (power of 2)
- DMEM_BIT, 20, address bit selecting dmem (1) vs imem (0)
- RD_LAT, 1, cycles from accepted request to rvalid (1..4)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NPORTS  per-port request
- we  in  NPORTS  per-port write enable
- be  in  4*NPORTS  byte enables, port p at [4p+3:4p]
- addr  in  32*NPORTS  byte address, port p at [32p+31:32p]
- wdata  in  32*NPORTS  write data
- gnt  out  NPORTS  request accepted this cycle
- rvalid  out  NPORTS  response valid
- rdata  out  32*NPORTS  read data, valid with rvalid
- err  out  NPORTS  error response, valid with rvalid

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset rst_n is asynchronous, active-low.
  - Reset clears all rvalid, err and rdata to 0 and clears the latency pipeline.
  - Memory contents are not reset; they are loaded by the bench.
- Acceptance:
  - Port p is accepted when req[p] & gnt[p].
  - Without the optional feature, gnt is constant 1, including during reset.
- Decode:
  - word index = addr[p][31:2].
  - dmem when addr[DMEM_BIT]=1, else imem.
  - Range check: the word index must be below IWORDS (imem) or DWORDS (dmem), and all addr bits above DMEM_BIT must be 0.
  - Any failure marks the access out-of-range.
- Write:
  - Occurs at the acceptance edge.
  - Byte-masked by be; a be=0 write leaves memory unchanged.
  - Out-of-range writes are suppressed.
- Read:
  - Data is sampled at the acceptance edge from pre-write contents (read-old on same-cycle collision with another port's write).
  - The sampled data is then delayed RD_LAT-1 further cycles.
- Response:
  - Every accepted request, read or write, produces exactly one rvalid pulse RD_LAT cycles later.
  - Read: rdata = word.
  - Write: rdata = 0.
  - Out-of-range: err=1, rdata=0.
  - When rvalid=0, rdata=0 and err=0.
- Pipelining: one request per port per cycle is allowed back-to-back. Responses are returned in order with no bubbles.
- Write collision: when several ports write the same word in one cycle, the lowest port index wins per enabled byte. Bytes enabled only by higher ports are still written.
- Reset mid-operation: in-flight responses are dropped with no rvalid. Writes already committed remain.
- Port independence: the ports have no arbitration between them beyond the collision rule.

Optional Feature:
- Macro ZERORISCY_MP_SRAM_RANDOM_STALL_EN.
- Defined:
  - Each port has a 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Reset seed: 16'hACE1 XOR p.
  - The LFSR advances every cycle.
  - gnt[p] = req[p] & ~lfsr[p][0].
  - A stalled request must be held stable by the master. Response latency counts from the granting cycle.
- Undefined: gnt is constant 1 and no LFSR logic exists.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst_n=0 for 3 cycles, then release with req=0.
  - Required: rvalid=0, err=0, rdata=0 throughout; gnt=1 (feature off).
- Write/read round trip, RD_LAT=1:
  - Stimulus: port1 writes 0xDEADBEEF to 0x00100010 with be=4'b1111. Next cycle, port0 reads 0x00100010.
  - Required: write rvalid with rdata=0; one cycle later, read rvalid with rdata=0xDEADBEEF.
- Byte mask:
  - Stimulus: preload imem[3]=0x11223344; write 0xAABBCCDD to 0x0000000C with be=4'b0101; then read 0x0000000C.
  - Required: read returns 0x11BB33DD.
- Collision:
  - Stimulus: same cycle, port0 writes 0x000000FF with be=0001 and port1 writes 0x0000EEEE with be=0011, both to 0x00100000. Then read 0x00100000.
  - Required: read returns 0x0000EEFF.
- Error and latency:
  - Stimulus: RD_LAT=3; read 0x00200000; then 4 back-to-back reads of 0x00100000–0x0010000C.
  - Required: first response has err=1, rdata=0, 3 cycles after acceptance; then 4 consecutive in-order rvalids with correct data.
- Random stall (feature on):
  - Stimulus: 1000 random accesses on both ports.
  - Required: gnt pattern matches the LFSR reference model; each accepted request gets exactly one rvalid RD_LAT cycles after its grant; final memory matches a scoreboard.

Source files
------------

// File: rtl/zeroriscy_mp_sram.sv
// ---------------------------------------------------------------------------
// zeroriscy_mp_sram
//
// Parametrised N-port instruction/data SRAM model for zero-riscy benches.
// Every port can read or write either the imem or the dmem region. Each
// accepted request returns exactly one response RD_LAT cycles later, in order.
//
// Ports (port p occupies slice p of each packed vector):
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   req     in   [NPORTS]    request
//   we      in   [NPORTS]    write enable
//   be      in   [4*NPORTS]  byte enables
//   addr    in   [32*NPORTS] byte address
//   wdata   in   [32*NPORTS] write data
//   gnt     out  [NPORTS]    request accepted this cycle
//   rvalid  out  [NPORTS]    response valid
//   rdata   out  [32*NPORTS] read data (0 for writes and errors)
//   err     out  [NPORTS]    out-of-range response
//
// Optional build macro ZERORISCY_MP_SRAM_RANDOM_STALL_EN:
//   defined   - per-port 16-bit LFSR randomly withholds gnt
//   undefined - gnt is constant 1
// ---------------------------------------------------------------------------
module zeroriscy_mp_sram #(
    parameter int NPORTS   = 2,
    parameter int IWORDS   = 4096,
    parameter int DWORDS   = 65536,
    parameter int DMEM_BIT = 20,
    parameter int RD_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NPORTS-1:0]      req,
    input  logic [NPORTS-1:0]      we,
    input  logic [4*NPORTS-1:0]    be,
    input  logic [32*NPORTS-1:0]   addr,
    input  logic [32*NPORTS-1:0]   wdata,
    output logic [NPORTS-1:0]      gnt,
    output logic [NPORTS-1:0]      rvalid,
    output logic [32*NPORTS-1:0]   rdata,
    output logic [NPORTS-1:0]      err
);

    localparam int IAW = $clog2(IWORDS);
    localparam int DAW = $clog2(DWORDS);

    // Storage is deliberately not reset; benches preload it.
    logic [31:0] r_imem [IWORDS];
    logic [31:0] r_dmem [DWORDS];

    logic [31:0]       w_addr     [NPORTS];
    logic [31:0]       w_off      [NPORTS];
    logic [31:0]       w_rdWord   [NPORTS];
    logic [31:0]       w_respData [NPORTS];
    logic [NPORTS-1:0] w_isD;
    logic [NPORTS-1:0] w_hiBad;
    logic [NPORTS-1:0] w_oor;
    logic [NPORTS-1:0] w_acc;

    // Latency pipeline; stage 0 is loaded at the acceptance edge.
    logic [NPORTS-1:0] r_pVal  [RD_LAT];
    logic [NPORTS-1:0] r_pErr  [RD_LAT];
    logic [31:0]       r_pData [RD_LAT][NPORTS];

`ifdef ZERORISCY_MP_SRAM_RANDOM_STALL_EN
    logic [15:0] r_lfsr [NPORTS];

    // Fibonacci LFSR per port (taps 16,14,13,11), free-running every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NPORTS; p++) begin
                r_lfsr[p] <= 16'hACE1 ^ 16'(p);
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                r_lfsr[p] <= {r_lfsr[p][14:0],
                              r_lfsr[p][15] ^ r_lfsr[p][13] ^ r_lfsr[p][12] ^ r_lfsr[p][10]};
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int p = 0; p < NPORTS; p++) begin
            gnt[p] = req[p] & ~r_lfsr[p][0];
        end
    end
`else
    assign gnt = '1;
`endif

    assign w_acc = req & gnt;

    // Address decode. The region-select bit is removed from the word index
    // so that each region's words start at offset 0; any address bit above
    // the select bit makes the access out of range.
    always_comb begin
        w_isD   = '0;
        w_hiBad = '0;
        w_oor   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            w_addr[p]     = addr[32*p +: 32];
            w_isD[p]      = w_addr[p][DMEM_BIT];
            w_off[p]      = {2'b00, w_addr[p][31:2]} & ~(32'd1 << (DMEM_BIT - 2));
            w_hiBad[p]    = (w_addr[p] >> (DMEM_BIT + 1)) != 32'd0;
            w_oor[p]      = w_hiBad[p] |
                            (w_isD[p] ? (w_off[p] >= 32'(DWORDS)) : (w_off[p] >= 32'(IWORDS)));
            w_rdWord[p]   = w_isD[p] ? r_dmem[w_off[p][DAW-1:0]] : r_imem[w_off[p][IAW-1:0]];
            w_respData[p] = (w_acc[p] & ~we[p] & ~w_oor[p]) ? w_rdWord[p] : 32'd0;
        end
    end

    // Byte-masked writes. Ports are visited from highest to lowest so the
    // lowest port's non-blocking update lands last and wins each shared byte.
    always_ff @(posedge clk) begin
        for (int p = NPORTS - 1; p >= 0; p--) begin
            if (w_acc[p] && we[p] && !w_oor[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[4*p + b]) begin
                        if (w_isD[p]) begin
                            r_dmem[w_off[p][DAW-1:0]][8*b +: 8] <= wdata[32*p + 8*b +: 8];
                        end else begin
                            r_imem[w_off[p][IAW-1:0]][8*b +: 8] <= wdata[32*p + 8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Response pipeline. Read data is captured from the pre-write contents at
    // the acceptance edge, then shifted RD_LAT-1 more stages. Non-valid stages
    // carry zero data and zero err so outputs are clean when rvalid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RD_LAT; s++) begin
                r_pVal[s] <= '0;
                r_pErr[s] <= '0;
                for (int p = 0; p < NPORTS; p++) begin
                    r_pData[s][p] <= '0;
                end
            end
        end else begin
            r_pVal[0] <= w_acc;
            r_pErr[0] <= w_acc & w_oor;
            for (int p = 0; p < NPORTS; p++) begin
                r_pData[0][p] <= w_respData[p];
            end
            for (int s = 1; s < RD_LAT; s++) begin
                r_pVal[s] <= r_pVal[s-1];
                r_pErr[s] <= r_pErr[s-1];
                for (int p = 0; p < NPORTS; p++) begin
                    r_pData[s][p] <= r_pData[s-1][p];
                end
            end
        end
    end

    assign rvalid = r_pVal[RD_LAT-1];
    assign err    = r_pErr[RD_LAT-1];

    always_comb begin
        rdata = '0;
        for (int p = 0; p < NPORTS; p++) begin
            rdata[32*p +: 32] = r_pData[RD_LAT-1][p];
        end
    end

endmodule

// File: tb/tb_zeroriscy_mp_sram.sv
// ---------------------------------------------------------------------------
// tb_zeroriscy_mp_sram
//
// Two DUT instances: A (default sizes, RD_LAT=1) and B (small memories,
// RD_LAT=3). Each accepted request pushes its expected response (due cycle,
// err, data) into a per-port queue; every negedge the queues are popped and
// compared against rvalid/err/rdata. A byte-level memory model supplies data.
// ---------------------------------------------------------------------------
module tb_zeroriscy_mp_sram;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

`ifdef ZERORISCY_MP_SRAM_RANDOM_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic [1:0]  reqA, weA, gntA, rvalidA, errA;
    logic [7:0]  beA;
    logic [63:0] addrA, wdataA, rdataA;
    logic [1:0]  reqB, weB, gntB, rvalidB, errB;
    logic [7:0]  beB;
    logic [63:0] addrB, wdataB, rdataB;

    zeroriscy_mp_sram #(.NPORTS(2), .IWORDS(4096), .DWORDS(65536), .DMEM_BIT(20), .RD_LAT(1)) dutA (
        .clk(clk), .rst_n(rst_n), .req(reqA), .we(weA), .be(beA), .addr(addrA),
        .wdata(wdataA), .gnt(gntA), .rvalid(rvalidA), .rdata(rdataA), .err(errA));

    zeroriscy_mp_sram #(.NPORTS(2), .IWORDS(256), .DWORDS(1024), .DMEM_BIT(20), .RD_LAT(3)) dutB (
        .clk(clk), .rst_n(rst_n), .req(reqB), .we(weB), .be(beB), .addr(addrB),
        .wdata(wdataB), .gnt(gntB), .rvalid(rvalidB), .rdata(rdataB), .err(errB));

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq [4][$];
    logic [31:0] mdl [longint];
    int          checks = 0;
    int          errors = 0;

`ifdef ZERORISCY_MP_SRAM_RANDOM_STALL_EN
    // Reference LFSRs, one per instance and port.
    logic [15:0] lm [2][2];
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rst_n) lm[i][p] <= 16'hACE1 ^ 16'(p);
                else        lm[i][p] <= {lm[i][p][14:0],
                                         lm[i][p][15] ^ lm[i][p][13] ^ lm[i][p][12] ^ lm[i][p][10]};
            end
        end
    end
`endif

    function automatic int latOf(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    function automatic int iwOf(input int inst);
        return (inst == 0) ? 4096 : 256;
    endfunction

    function automatic int dwOf(input int inst);
        return (inst == 0) ? 65536 : 1024;
    endfunction

    function automatic logic [1:0] expGntOf(input int inst, input logic [1:0] rq);
        logic [1:0] g;
        g = 2'b11;
`ifdef ZERORISCY_MP_SRAM_RANDOM_STALL_EN
        for (int p = 0; p < 2; p++) g[p] = rq[p] & ~lm[inst][p][0];
`else
        if (rq == 2'b10 && inst > 5) g = 2'b00;
`endif
        return g;
    endfunction

    // Range check and model key for one address.
    task automatic decode(input int inst, input logic [31:0] a, output logic oor, output longint key);
        logic [31:0] off;
        int          lim;
        off = {2'b00, a[31:2]} & ~(32'd1 << 18);
        lim = a[20] ? dwOf(inst) : iwOf(inst);
        oor = ((a >> 21) != 32'd0) || (off >= 32'(lim));
        key = longint'(inst) * 64'h1_0000_0000 + longint'(a[31:2]);
    endtask

    task automatic setIn(input int inst, input logic [1:0] rq, input logic [1:0] wr,
                         input logic [7:0] bes, input logic [63:0] ad, input logic [63:0] wd);
        if (inst == 0) begin
            reqA = rq; weA = wr; beA = bes; addrA = ad; wdataA = wd;
        end else begin
            reqB = rq; weB = wr; beB = bes; addrB = ad; wdataB = wd;
        end
    endtask

    // Pops and compares responses for every port of both instances.
    task automatic monitor();
        logic [1:0]  rv, er;
        logic [63:0] rd;
        exp_t        e;
        int          k;
        for (int inst = 0; inst < 2; inst++) begin
            rv = (inst == 0) ? rvalidA : rvalidB;
            er = (inst == 0) ? errA : errB;
            rd = (inst == 0) ? rdataA : rdataB;
            for (int p = 0; p < 2; p++) begin
                k = inst * 2 + p;
                checks++;
                if (rv[p]) begin
                    if (sbq[k].size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_rvalid inst%0d port%0d cyc %0d got rdata %h", inst, p, cycleCnt, rd[32*p +: 32]);
                    end else begin
                        e = sbq[k].pop_front();
                        if (cycleCnt != e.due || er[p] !== e.err || rd[32*p +: 32] !== e.data) begin
                            errors++;
                            $display("[TB] FAIL response inst%0d port%0d got cyc %0d err %b rdata %h, want cyc %0d err %b rdata %h",
                                     inst, p, cycleCnt, er[p], rd[32*p +: 32], e.due, e.err, e.data);
                        end
                    end
                end else begin
                    if (er[p] !== 1'b0 || rd[32*p +: 32] !== 32'd0) begin
                        errors++;
                        $display("[TB] FAIL idle_outputs inst%0d port%0d got err %b rdata %h want 0", inst, p, er[p], rd[32*p +: 32]);
                    end
                    if (sbq[k].size() != 0 && sbq[k][0].due <= cycleCnt) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL missing_rvalid inst%0d port%0d got none want rvalid at cyc %0d", inst, p, sbq[k][0].due);
                        void'(sbq[k].pop_front());
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Drives one request set, holding each port until granted. Expected
    // responses come from the model, or from expData for reads where useExp set.
    task automatic drive(input int inst, input logic [1:0] rq, input logic [1:0] wr,
                         input logic [7:0] bes, input logic [63:0] ad, input logic [63:0] wd,
                         input logic [1:0] useExp, input logic [63:0] expData);
        logic [1:0]  pending, g, eg, acc;
        logic [31:0] rdv [2];
        logic        oo  [2];
        longint      key [2];
        logic [31:0] w;
        exp_t        e;
        int          guard;
        pending = rq;
        guard   = 0;
        while (pending != 2'b00 && guard < 64) begin
            setIn(inst, pending, wr, bes, ad, wd);
            #1;
            g  = (inst == 0) ? gntA : gntB;
            eg = expGntOf(inst, pending);
            checks++;
            if (g !== eg) begin
                errors++;
                $display("[TB] FAIL gnt inst%0d got %b want %b", inst, g, eg);
            end
            acc = pending & eg;
            for (int p = 0; p < 2; p++) begin
                decode(inst, ad[32*p +: 32], oo[p], key[p]);
                rdv[p] = 32'd0;
                if (acc[p] && !wr[p] && !oo[p]) begin
                    if (useExp[p] && !STALL) rdv[p] = expData[32*p +: 32];
                    else if (mdl.exists(key[p])) rdv[p] = mdl[key[p]];
                end
                if (acc[p]) begin
                    e.due  = cycleCnt + latOf(inst);
                    e.err  = oo[p];
                    e.data = rdv[p];
                    sbq[inst*2 + p].push_back(e);
                end
            end
            for (int p = 1; p >= 0; p--) begin
                if (acc[p] && wr[p] && !oo[p]) begin
                    w = mdl.exists(key[p]) ? mdl[key[p]] : 32'd0;
                    for (int b = 0; b < 4; b++) begin
                        if (bes[4*p + b]) w[8*b +: 8] = wd[32*p + 8*b +: 8];
                    end
                    mdl[key[p]] = w;
                end
            end
            step();
            pending = pending & ~acc;
            guard++;
        end
        if (pending != 2'b00) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout inst%0d got pending %b want 00", inst, pending);
        end
        setIn(inst, 2'b00, 2'b00, 8'h00, 64'd0, 64'd0);
    endtask

    task automatic wr1(input int inst, input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        drive(inst, 2'(1 << p), 2'(1 << p), 8'({4'b0, b} << (4*p)),
              64'({32'b0, a} << (32*p)), 64'({32'b0, d} << (32*p)), 2'b00, 64'd0);
    endtask

    task automatic rd1(input int inst, input int p, input logic [31:0] a, input logic [31:0] want);
        drive(inst, 2'(1 << p), 2'b00, 8'h00, 64'({32'b0, a} << (32*p)), 64'd0,
              2'(1 << p), 64'({32'b0, want} << (32*p)));
    endtask

    task automatic test_reset();
        logic [1:0] eg;
        rst_n = 1'b0;
        setIn(0, 2'b00, 2'b00, 8'h00, 64'd0, 64'd0);
        setIn(1, 2'b00, 2'b00, 8'h00, 64'd0, 64'd0);
        repeat (3) begin
            @(negedge clk);
            eg = expGntOf(0, 2'b00);
            checks++;
            if (rvalidA !== 2'b00 || errA !== 2'b00 || rdataA !== 64'd0 ||
                rvalidB !== 2'b00 || errB !== 2'b00 || rdataB !== 64'd0 || gntA !== eg) begin
                errors++;
                $display("[TB] FAIL reset_outputs got rvalid %b/%b err %b/%b gnt %b want zeros gnt %b",
                         rvalidA, rvalidB, errA, errB, gntA, eg);
            end
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_round_trip();
        wr1(0, 1, 32'h00100010, 32'hDEADBEEF, 4'b1111);
        rd1(0, 0, 32'h00100010, 32'hDEADBEEF);
        idle(2);
    endtask

    task automatic test_byte_mask();
        wr1(0, 0, 32'h0000000C, 32'h11223344, 4'b1111);
        wr1(0, 1, 32'h0000000C, 32'hAABBCCDD, 4'b0101);
        wr1(0, 1, 32'h0000000C, 32'h99999999, 4'b0000);
        rd1(0, 0, 32'h0000000C, 32'h11BB33DD);
        idle(2);
    endtask

    task automatic test_collision();
        wr1(0, 0, 32'h00100000, 32'h00000000, 4'b1111);
        drive(0, 2'b11, 2'b11, 8'b0011_0001, {32'h00100000, 32'h00100000},
              {32'h0000EEEE, 32'h000000FF}, 2'b00, 64'd0);
        rd1(0, 1, 32'h00100000, 32'h0000EEFF);
        // Read on port 0 sees the old word while port 1 overwrites it.
        drive(0, 2'b11, 2'b10, 8'hF0, {32'h00100000, 32'h00100000},
              {32'h12345678, 32'h0}, 2'b01, {32'h0, 32'h0000EEFF});
        rd1(0, 0, 32'h00100000, 32'h12345678);
        idle(2);
    endtask

    task automatic test_boundary();
        wr1(0, 0, 32'h00000000, 32'h01020304, 4'b1111);
        rd1(0, 0, 32'h00140000, 32'h0);
        rd1(0, 1, 32'h00004000, 32'h0);
        wr1(0, 0, 32'h00004000, 32'hFFFFFFFF, 4'b1111);
        wr1(0, 1, 32'h80000000, 32'hFFFFFFFF, 4'b1111);
        rd1(0, 0, 32'h00000000, 32'h01020304);
        rd1(0, 1, 32'h000FFFFC, 32'h0);
        idle(2);
    endtask

    task automatic test_error_latency();
        for (int i = 0; i < 4; i++) wr1(1, 0, 32'h00100000 + 32'(4*i), 32'hA0000000 + 32'(i), 4'b1111);
        rd1(1, 0, 32'h00200000, 32'h0);
        for (int i = 0; i < 4; i++) rd1(1, 0, 32'h00100000 + 32'(4*i), 32'hA0000000 + 32'(i));
        drive(1, 2'b11, 2'b00, 8'h00, {32'h0010000C, 32'h00000400}, 64'd0,
              2'b10, {32'hA0000003, 32'h0});
        idle(5);
    endtask

    task automatic test_reset_mid();
        wr1(1, 0, 32'h00100020, 32'h55AA55AA, 4'b1111);
        rd1(1, 1, 32'h00100000, 32'hA0000000);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rvalidB !== 2'b00 || rdataB !== 64'd0 || errB !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_mid got rvalid %b rdata %h want 0", rvalidB, rdataB);
        end
        for (int k = 0; k < 4; k++) sbq[k].delete();
        idle(3);
        rst_n = 1'b1;
        step();
        rd1(1, 0, 32'h00100020, 32'h55AA55AA);
        idle(4);
    endtask

    function automatic logic [31:0] pickAddr(input int r);
        if (r < 8)       return 32'h00100100 + 32'(4*r);
        else if (r < 16) return 32'h00000040 + 32'(4*(r-8));
        else             return 32'h00300000;
    endfunction

    task automatic test_random();
        logic [63:0] ad;
        for (int i = 0; i < 16; i++) wr1(0, i % 2, pickAddr(i), $urandom, 4'b1111);
        for (int n = 0; n < 500; n++) begin
            ad = {pickAddr($urandom_range(0, 16)), pickAddr($urandom_range(0, 16))};
            drive(0, 2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom), ad,
                  {32'($urandom), 32'($urandom)}, 2'b00, 64'd0);
        end
        for (int i = 0; i < 16; i++) drive(0, 2'b10, 2'b00, 8'h00, {pickAddr(i), 32'h0}, 64'd0, 2'b00, 64'd0);
        idle(5);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sbq[k].size() != 0) begin
                errors++;
                $display("[TB] FAIL drain queue%0d got %0d pending want 0", k, sbq[k].size());
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_round_trip();
        test_byte_mask();
        test_collision();
        test_boundary();
        test_error_latency();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
